// File: rtl/board_write_scheduler_if.sv
//------------------------------------------------------------------------------
// board_write_scheduler_if
//
// Purpose : Bundles the renderer read port, the game-logic write/clear port and
//           the scheduler status outputs of board_write_scheduler.
//
// Signals :
//   blank      - high while the VGA counters are outside the visible region
//   rd_row     - renderer cell row    (0..9 valid, >= 10 off-grid)
//   rd_col     - renderer cell column (0..9 valid, >= 10 off-grid)
//   rd_state   - registered cell state (0 EMPTY, 1 SHIP, 2 MISS, 3 HIT)
//   wr_valid   - write request
//   wr_ready   - write FIFO can accept
//   wr_row     - write payload row
//   wr_col     - write payload column
//   wr_state   - write payload cell state
//   clr_req    - single-cycle pulse requesting a full board clear
//   busy       - clear pending/in progress or FIFO non-empty
//   fifo_count - entries held in the write FIFO
//   commit     - high for the cycle a FIFO entry is written to the board
//   drop_err   - sticky flag, a committed entry had out-of-range coordinates
//
// Modports:
//   master - game FSM / VGA pixel path side (drives requests, reads status)
//   slave  - board_write_scheduler side
//------------------------------------------------------------------------------
`timescale 1ns/1ps

interface board_write_scheduler_if #(
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             blank;
    logic [3:0]       rd_row;
    logic [3:0]       rd_col;
    logic [1:0]       rd_state;
    logic             wr_valid;
    logic             wr_ready;
    logic [3:0]       wr_row;
    logic [3:0]       wr_col;
    logic [1:0]       wr_state;
    logic             clr_req;
    logic             busy;
    logic [CNT_W-1:0] fifo_count;
    logic             commit;
    logic             drop_err;

    modport master (
        output blank, rd_row, rd_col, wr_valid, wr_row, wr_col, wr_state, clr_req,
        input  rd_state, wr_ready, busy, fifo_count, commit, drop_err
    );

    modport slave (
        input  blank, rd_row, rd_col, wr_valid, wr_row, wr_col, wr_state, clr_req,
        output rd_state, wr_ready, busy, fifo_count, commit, drop_err
    );

endinterface

// File: rtl/board_write_scheduler.sv
//------------------------------------------------------------------------------
// board_write_scheduler
//
// Purpose : Owns the ROWSxCOLS battleship board (2 bits per cell) and makes sure
//           it only changes while the display is blanked. Game-logic writes are
//           buffered in a small FIFO and whole-board clears are held pending;
//           both are applied one cell per blank cycle. The renderer read port is
//           served every cycle with one cycle of latency.
//
// Ports   :
//   clk_vga - 25 MHz VGA clock
//   rst_n   - asynchronous active-low reset
//   bus     - board_write_scheduler_if.slave (read port, write/clear port,
//             status outputs)
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module board_write_scheduler #(
    parameter int DEPTH = 4,
    parameter int ROWS  = 10,
    parameter int COLS  = 10
) (
    input  logic                          clk_vga,
    input  logic                          rst_n,
    board_write_scheduler_if.slave        bus
);

    localparam int CELLS = ROWS * COLS;
    localparam int IDX_W = $clog2(CELLS);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(CELLS - 1);
    localparam logic [1:0]       CELL_EMPTY = 2'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_COMMIT
    } state_t;

    typedef struct packed {
        logic [3:0] row;
        logic [3:0] col;
        logic [1:0] state;
    } entry_t;

    function automatic logic [IDX_W-1:0] cell_idx(input logic [3:0] row,
                                                  input logic [3:0] col);
        return IDX_W'(row) * IDX_W'(COLS) + IDX_W'(col);
    endfunction

    // Board, FIFO and controller state
    logic [1:0]       r_board [CELLS];
    entry_t           r_fifo  [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic             r_pending;
    logic             r_busy;
    logic             r_drop;
    logic [1:0]       r_rd_state;

    state_t           w_state_nxt;
    logic [IDX_W-1:0] w_idx_nxt;
    logic             w_pending_nxt;
    logic             w_clr_write;
    logic             w_wr_ready;
    logic             w_push;
    logic             w_pop;
    logic [CNT_W-1:0] w_count_nxt;
    entry_t           w_head;
    logic             w_head_ok;
    logic [IDX_W-1:0] w_head_idx;
    logic             w_rd_hit;
    logic [1:0]       w_rd_val;

    //--------------------------------------------------------------------------
    // FIFO handshake. wr_ready comes only from the registered count, so a full
    // FIFO refuses a push even in a cycle where it is also popping.
    //--------------------------------------------------------------------------
    assign w_wr_ready  = (r_count < CNT_W'(DEPTH));
    assign w_push      = bus.wr_valid && w_wr_ready;
    assign w_pop       = (r_state == S_COMMIT) && bus.blank && (r_count != '0);
    assign w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

    assign w_head      = r_fifo[r_rd_ptr];
    assign w_head_ok   = (w_head.row < 4'(ROWS)) && (w_head.col < 4'(COLS));
    assign w_head_idx  = cell_idx(w_head.row, w_head.col);

    // NOTE: the FIFO payload array has no reset; only pointers and count decide
    //       what is valid. The board itself is reset because a freshly reset
    //       screen must show an empty grid.
    always_ff @(posedge clk_vga) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= '{row: bus.wr_row, col: bus.wr_col, state: bus.wr_state};
        end
    end

    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap on overflow.
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_nxt;
        end
    end

    //--------------------------------------------------------------------------
    // Controller: a pending clear always wins over queued writes, so writes
    // queued before or during a clear land on the freshly cleared board.
    //--------------------------------------------------------------------------
    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_pending <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_pending <= w_pending_nxt;
            r_busy    <= w_pending_nxt || (w_state_nxt == S_CLEAR) || (w_count_nxt != '0);
        end
    end

    // NOTE: combinational logic uses blocking assignments and gives every output
    //       a default first, so no path can leave a value held (no latches).
    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_clr_write   = 1'b0;
        w_pending_nxt = r_pending || bus.clr_req;

        unique case (r_state)
            S_IDLE: begin
                if (r_pending) begin
                    w_state_nxt = S_CLEAR;
                    w_idx_nxt   = '0;
                end else if (r_count != '0) begin
                    w_state_nxt = S_COMMIT;
                end
            end

            S_CLEAR: begin
                w_clr_write = bus.blank;
                if (bus.clr_req) begin
                    // A new request while clearing starts the sweep over.
                    w_idx_nxt = '0;
                end else if (bus.blank) begin
                    if (r_idx == LAST_IDX) begin
                        w_state_nxt   = S_IDLE;
                        w_idx_nxt     = '0;
                        w_pending_nxt = 1'b0;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end

            S_COMMIT: begin
                // Any pop this cycle still completes; the clear follows.
                if (r_pending) begin
                    w_state_nxt = S_CLEAR;
                    w_idx_nxt   = '0;
                end else if (w_count_nxt == '0) begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // Board storage. Clear and commit are exclusive by controller state, and
    // both are qualified by blank so the array never changes in active video.
    // Out-of-range entries are popped without touching the board.
    //--------------------------------------------------------------------------
    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CELLS; i++) begin
                r_board[i] <= CELL_EMPTY;
            end
        end else if (w_clr_write) begin
            r_board[r_idx] <= CELL_EMPTY;
        end else if (w_pop && w_head_ok) begin
            r_board[w_head_idx] <= w_head.state;
        end
    end

    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            r_drop <= 1'b0;
        end else if (w_pop && !w_head_ok) begin
            r_drop <= 1'b1;
        end
    end

    //--------------------------------------------------------------------------
    // Renderer read port: samples the board before any same-edge update, so a
    // cell being committed reads back its old value this cycle.
    //--------------------------------------------------------------------------
    assign w_rd_hit = (bus.rd_row < 4'(ROWS)) && (bus.rd_col < 4'(COLS));
    assign w_rd_val = w_rd_hit ? r_board[cell_idx(bus.rd_row, bus.rd_col)] : CELL_EMPTY;

    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_state <= CELL_EMPTY;
        end else begin
            r_rd_state <= w_rd_val;
        end
    end

    assign bus.rd_state   = r_rd_state;
    assign bus.wr_ready   = w_wr_ready;
    assign bus.busy       = r_busy;
    assign bus.fifo_count = r_count;
    assign bus.commit     = w_pop;
    assign bus.drop_err   = r_drop;

endmodule
